// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 digest output path.
package sha256_pkg;

    localparam int DIGEST_BITS = 256;

    typedef logic [DIGEST_BITS-1:0] digest_t;

    // FIPS 180-4 initial hash value, H0 in the top word.
    localparam digest_t H0_INIT = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic {IDLE, SEND} stream_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sha256_digest_streamer_if.sv
// Digest input and word-stream output bundle of the digest streamer.
interface sha256_digest_streamer_if #(
    parameter int WORD_BITS = 32
);
    import sha256_pkg::*;

    logic                 digest_valid;
    digest_t              digest;
    logic                 out_ready;
    logic                 out_valid;
    logic [WORD_BITS-1:0] out_data;
    logic                 out_last;

    // master is the streamer itself, slave is the hash core plus consumer side.
    modport master (
        input  digest_valid, digest, out_ready,
        output out_valid, out_data, out_last
    );

    modport slave (
        output digest_valid, digest, out_ready,
        input  out_valid, out_data, out_last
    );

endinterface

// File: rtl/sha256_digest_holdbuf.sv
// One-entry digest hold buffer; a store in the same cycle as a drain refills it.
module sha256_digest_holdbuf
    import sha256_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    store,
    input  logic    drain,
    input  digest_t data_in,
    output logic    full,
    output digest_t data_out
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full     <= 1'b0;
            data_out <= '0;
        end else if (store) begin
            full     <= 1'b1;
            data_out <= data_in;
        end else if (drain) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/sha256_digest_streamer.sv
// Captures a 256-bit digest and streams it out H0-word first over valid/ready.
// Define SHA256_DIGEST_HOLD_EN to add a one-entry hold buffer for digests arriving mid-stream.
module sha256_digest_streamer
    import sha256_pkg::*;
#(
    parameter int WORD_BITS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    sha256_digest_streamer_if.master bus,
    input  logic                     overrun_clr,
    output logic                     busy,
    output logic                     overrun
);

    localparam int NUM_WORDS = DIGEST_BITS / WORD_BITS;
    localparam int CNT_W     = cnt_width(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    stream_state_t        state;
    digest_t              shift_reg;
    digest_t              shifted;
    logic [CNT_W-1:0]     word_cnt;
    logic                 out_valid_q;
    logic [WORD_BITS-1:0] out_data_q;
    logic                 out_last_q;

    logic    xfer;
    logic    last_xfer;
    logic    load_en;
    digest_t load_val;
    logic    overrun_set;
    logic    hold_full_next;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    assign xfer      = out_valid_q & bus.out_ready;
    assign last_xfer = xfer & out_last_q;
    assign shifted   = shift_reg << WORD_BITS;

`ifdef SHA256_DIGEST_HOLD_EN
    logic    hold_full;
    logic    hold_store;
    logic    hold_drain;
    digest_t hold_data;

    sha256_digest_holdbuf u_holdbuf (
        .clk      (clk),
        .reset    (reset),
        .store    (hold_store),
        .drain    (hold_drain),
        .data_in  (bus.digest),
        .full     (hold_full),
        .data_out (hold_data)
    );
`endif

    // Decide what gets loaded next: a fresh digest, the held digest, or nothing.
    always_comb begin
        load_en        = 1'b0;
        load_val       = bus.digest;
        overrun_set    = 1'b0;
        hold_full_next = 1'b0;
`ifdef SHA256_DIGEST_HOLD_EN
        hold_store     = 1'b0;
        hold_drain     = 1'b0;
`endif
        case (state)
            IDLE: load_en = bus.digest_valid;
            SEND: begin
`ifdef SHA256_DIGEST_HOLD_EN
                if (last_xfer && hold_full) begin
                    load_en    = 1'b1;
                    load_val   = hold_data;
                    hold_drain = 1'b1;
                    hold_store = bus.digest_valid;
                end else if (last_xfer) begin
                    load_en = bus.digest_valid;
                end else if (bus.digest_valid) begin
                    if (hold_full) overrun_set = 1'b1;
                    else           hold_store  = 1'b1;
                end
`else
                if (last_xfer) load_en     = bus.digest_valid;
                else           overrun_set = bus.digest_valid;
`endif
            end
            default: load_en = 1'b0;
        endcase
`ifdef SHA256_DIGEST_HOLD_EN
        hold_full_next = hold_store | (hold_full & ~hold_drain);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            word_cnt    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (load_en) begin
                state       <= SEND;
                shift_reg   <= load_val;
                word_cnt    <= '0;
                out_valid_q <= 1'b1;
                out_data_q  <= load_val[DIGEST_BITS-1 -: WORD_BITS];
                out_last_q  <= (LAST_IDX == '0);
            end else if (last_xfer) begin
                state       <= IDLE;
                shift_reg   <= '0;
                word_cnt    <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_last_q  <= 1'b0;
            end else if (xfer) begin
                shift_reg   <= shifted;
                word_cnt    <= word_cnt + CNT_W'(1);
                out_data_q  <= shifted[DIGEST_BITS-1 -: WORD_BITS];
                out_last_q  <= ((word_cnt + CNT_W'(1)) == LAST_IDX);
            end
            busy <= load_en | ((state == SEND) & ~last_xfer) | hold_full_next;
        end
    end

    // Sticky drop flag; a new drop beats a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           overrun <= 1'b0;
        else if (overrun_set) overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_sha256_digest_streamer.sv
// Directed self-checking bench for sha256_digest_streamer (WORD_BITS=32).
module tb_sha256_digest_streamer;
    import sha256_pkg::*;

    localparam digest_t D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam digest_t D_SEQ = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;

    logic clk = 1'b0;
    logic reset;
    logic overrun_clr;
    logic busy;
    logic overrun;
    int   checks = 0;
    int   passes = 0;
    logic [31:0] exp_words [8];

    sha256_digest_streamer_if #(.WORD_BITS(32)) bus ();

    sha256_digest_streamer #(.WORD_BITS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .overrun_clr (overrun_clr),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_digest(input digest_t d);
        bus.digest_valid = 1'b1;
        bus.digest       = d;
        tick();
        bus.digest_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.digest_valid = 1'b0;
        bus.digest = '0;
        bus.out_ready = 1'b0;
        overrun_clr = 1'b0;
        #3;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 32'h0) $display("[TB] FAIL reset_data: got %h expected 0", bus.out_data); else passes++;
        checks++; if (bus.out_last !== 1'b0) $display("[TB] FAIL reset_last: got %b expected 0", bus.out_last); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else passes++;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL idle_after_reset: got %b expected 0", bus.out_valid); else passes++;
    endtask

    task automatic test_basic_stream();
        bus.out_ready = 1'b1;
        start_digest(D_ABC);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1", busy); else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL basic_valid[%0d]: got %b expected 1", i, bus.out_valid); else passes++;
            checks++; if (bus.out_data !== exp_words[i]) $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, bus.out_data, exp_words[i]); else passes++;
            checks++; if (bus.out_last !== (i == 7)) $display("[TB] FAIL basic_last[%0d]: got %b expected %b", i, bus.out_last, (i == 7)); else passes++;
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL basic_end_valid: got %b expected 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 32'h0) $display("[TB] FAIL basic_end_data: got %h expected 0", bus.out_data); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_end_busy: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_backpressure();
        int  idx = 0;
        int  cyc = 0;
        logic rdy;
        start_digest(D_ABC);
        while (idx < 8 && cyc < 60) begin
            checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", cyc, bus.out_valid); else passes++;
            checks++; if (bus.out_data !== exp_words[idx]) $display("[TB] FAIL bp_data[%0d]: got %h expected %h", cyc, bus.out_data, exp_words[idx]); else passes++;
            checks++; if (bus.out_last !== (idx == 7)) $display("[TB] FAIL bp_last[%0d]: got %b expected %b", cyc, bus.out_last, (idx == 7)); else passes++;
            rdy = ((cyc % 3) == 0);
            bus.out_ready = rdy;
            tick();
            if (rdy) idx++;
            cyc++;
        end
        checks++; if (idx !== 8) $display("[TB] FAIL bp_budget: got %0d words expected 8", idx); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bp_end_valid: got %b expected 0", bus.out_valid); else passes++;
        bus.out_ready = 1'b1;
    endtask

`ifndef SHA256_DIGEST_HOLD_EN
    task automatic test_overrun();
        bus.out_ready = 1'b1;
        start_digest(D_ABC);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.out_data !== exp_words[i]) $display("[TB] FAIL ovr_data[%0d]: got %h expected %h", i, bus.out_data, exp_words[i]); else passes++;
            if (i == 3) begin
                bus.digest_valid = 1'b1;
                bus.digest = '0;
            end
            tick();
            bus.digest_valid = 1'b0;
        end
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL ovr_end_valid: got %b expected 0", bus.out_valid); else passes++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL ovr_busy: got %b expected 0", busy); else passes++;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); else passes++;
    endtask
`else
    task automatic test_hold();
        bus.out_ready = 1'b1;
        start_digest(D_ABC);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.out_data !== exp_words[i]) $display("[TB] FAIL hold_first[%0d]: got %h expected %h", i, bus.out_data, exp_words[i]); else passes++;
            bus.digest_valid = (i == 2) || (i == 4);
            bus.digest = (i == 2) ? D_SEQ : H0_INIT;
            tick();
            bus.digest_valid = 1'b0;
        end
        for (int j = 0; j < 8; j++) begin
            checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", j, bus.out_valid); else passes++;
            checks++; if (bus.out_data !== 32'(j + 1)) $display("[TB] FAIL hold_data[%0d]: got %h expected %h", j, bus.out_data, 32'(j + 1)); else passes++;
            tick();
        end
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL hold_overrun: got %b expected 1", overrun); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL hold_end_busy: got %b expected 0", busy); else passes++;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL hold_clear: got %b expected 0", overrun); else passes++;
    endtask
`endif

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        start_digest(D_ABC);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                bus.digest_valid = 1'b1;
                bus.digest = '1;
            end
            tick();
            bus.digest_valid = 1'b0;
        end
        checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b expected 1", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 32'hffffffff) $display("[TB] FAIL b2b_data: got %h expected ffffffff", bus.out_data); else passes++;
        checks++; if (bus.out_last !== 1'b0) $display("[TB] FAIL b2b_last: got %b expected 0", bus.out_last); else passes++;
        checks++; if (dut.word_cnt !== 3'd0) $display("[TB] FAIL b2b_cnt: got %0d expected 0", dut.word_cnt); else passes++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL b2b_busy: got %b expected 1", busy); else passes++;
        for (int j = 0; j < 8; j++) begin
            checks++; if (bus.out_data !== 32'hffffffff) $display("[TB] FAIL b2b_word[%0d]: got %h expected ffffffff", j, bus.out_data); else passes++;
            checks++; if (bus.out_last !== (j == 7)) $display("[TB] FAIL b2b_wlast[%0d]: got %b expected %b", j, bus.out_last, (j == 7)); else passes++;
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL b2b_end_valid: got %b expected 0", bus.out_valid); else passes++;
    endtask

    task automatic test_reset_mid_stream();
        bus.out_ready = 1'b1;
        start_digest(D_ABC);
        for (int i = 0; i < 5; i++) begin
            bus.digest_valid = (i >= 1) && (i <= 3);
            bus.digest = H0_INIT;
            tick();
        end
        bus.digest_valid = 1'b0;
        checks++; if (bus.out_data !== exp_words[5]) $display("[TB] FAIL rst_pre_data: got %h expected %h", bus.out_data, exp_words[5]); else passes++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL rst_pre_overrun: got %b expected 1", overrun); else passes++;
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_async_valid: got %b expected 0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 32'h0) $display("[TB] FAIL rst_async_data: got %h expected 0", bus.out_data); else passes++;
        checks++; if (bus.out_last !== 1'b0) $display("[TB] FAIL rst_async_last: got %b expected 0", bus.out_last); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL rst_async_overrun: got %b expected 0", overrun); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_async_busy: got %b expected 0", busy); else passes++;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_idle_valid[%0d]: got %b expected 0", k, bus.out_valid); else passes++;
            checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_idle_busy[%0d]: got %b expected 0", k, busy); else passes++;
        end
        start_digest(D_ABC);
        checks++; if (bus.out_data !== exp_words[0]) $display("[TB] FAIL rst_restart_data: got %h expected %h", bus.out_data, exp_words[0]); else passes++;
        checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL rst_restart_valid: got %b expected 1", bus.out_valid); else passes++;
        for (int j = 0; j < 8; j++) tick();
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_restart_end: got %b expected 0", bus.out_valid); else passes++;
    endtask

    initial begin
        exp_words[0] = 32'hba7816bf;
        exp_words[1] = 32'h8f01cfea;
        exp_words[2] = 32'h414140de;
        exp_words[3] = 32'h5dae2223;
        exp_words[4] = 32'hb00361a3;
        exp_words[5] = 32'h96177a9c;
        exp_words[6] = 32'hb410ff61;
        exp_words[7] = 32'hf20015ad;
        test_reset();
        test_basic_stream();
        test_backpressure();
`ifndef SHA256_DIGEST_HOLD_EN
        test_overrun();
`else
        test_hold();
`endif
        test_back_to_back();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sha256_digest_streamer.md
Name: sha256_digest_streamer

Overview:
- Output-side counterpart of the hash core. Captures the 256-bit digest when the core flags completion.
- Transmits the digest as a stream of WORD_BITS-wide words over a valid/ready handshake, most-significant word (H0) first.
- Sits between the hash top level and any downstream consumer (UART bridge, bus slave, compare logic), so the consumer never samples the wide H_out bus directly.

Parameters:
- WORD_BITS, 32, output word width; must be 8, 16, 32 or 64 (divides 256).
- NUM_WORDS, 256/WORD_BITS, derived localparam; words per digest.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- digest_valid  input  1  one-cycle pulse: digest is valid this cycle.
- digest  input  256  digest value; sampled only when digest_valid=1.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WORD_BITS  current digest word.
- out_last  output  1  current word is the final word of the digest.
- busy  output  1  a digest is held or being sent.
- overrun  output  1  sticky flag: a digest was dropped.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (reset=0, async): state=IDLE, word counter=0, shift register=0, out_valid=0, out_data=0, out_last=0, busy=0, overrun=0.
- States:
  - IDLE: out_valid=0.
  - SEND: out_valid=1.
- IDLE -> SEND: on digest_valid=1, load digest into the shift register and set counter=0.
- Latency: digest_valid at edge N gives out_valid=1 with word 0 = digest[255:256-WORD_BITS] after edge N.
- Handshake:
  - A word transfers on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops until the last word transfers.
- Per transfer: shift left by WORD_BITS and increment the counter.
- out_last=1 exactly when counter==NUM_WORDS-1.
- SEND -> IDLE: on the last-word transfer with no new digest available.
- Simultaneous digest_valid and last-word transfer: the new digest is accepted and loaded; state stays SEND; word 0 of the new digest is presented the next cycle (no bubble).
- digest_valid in SEND, not on the last-word transfer: the digest is dropped and overrun set to 1 (base build).
- overrun stays 1 until overrun_clr=1. If overrun_clr and a new overrun occur in the same cycle, set wins.
- busy=1 in SEND (or when the hold buffer is full); otherwise 0.
- out_data=0 whenever out_valid=0.
- Counter width is clog2(NUM_WORDS), minimum 1 bit. For WORD_BITS=256-equivalent cases the counter still wraps to 0 after the last transfer.
- Reset asserted mid-digest: transfer aborts immediately, all outputs return to reset values, and the partial digest is discarded.

Optional Feature:
- Macro: SHA256_DIGEST_HOLD_EN.
- Defined:
  - Adds a one-entry 256-bit hold buffer with a valid bit.
  - digest_valid in SEND stores the digest in the buffer, if empty.
  - On the last-word transfer, a full buffer is moved into the shift register with no bubble and the buffer is emptied.
  - overrun is set only when digest_valid arrives while the buffer is already full (and not draining that cycle). A drain plus a simultaneous arrival refills the buffer.
  - busy is also 1 while the buffer is full.
- Undefined: no buffer; drop/overrun rules as above.

Decomposition:
- Package sha256_pkg:
  - DIGEST_BITS=256.
  - H0 initial-hash constant.
  - typedef enum logic {IDLE, SEND} stream_state_t.
  - typedef logic [255:0] digest_t.
- One sub-module: sha256_digest_holdbuf, the one-entry hold buffer instantiated under SHA256_DIGEST_HOLD_EN.

Test Plan:
- Basic stream:
  - Stimulus: reset released; pulse digest_valid with digest=ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad; out_ready=1.
  - Required: 8 words ba7816bf..f20015ad on consecutive cycles starting 1 cycle after the pulse; out_last only on f20015ad; then out_valid=0, busy=0.
- Backpressure:
  - Stimulus: same digest; out_ready toggles 1,0,0,1,...
  - Required: each word is held stable while ready=0; sequence and order unchanged; no duplicate or skipped word.
- Overrun (base build):
  - Stimulus: second digest_valid (digest=0) while on word 3.
  - Required: original digest completes intact; overrun=1; then overrun_clr gives overrun=0 the next cycle.
- Back-to-back:
  - Stimulus: digest_valid with digest=all-ones on the same cycle as the last-word transfer.
  - Required: next cycle out_valid=1, out_data=ffffffff, counter=0.
- Hold buffer (SHA256_DIGEST_HOLD_EN):
  - Stimulus: two digests during SEND.
  - Required: first queued digest streams immediately after the current one; second arrival sets overrun.
- Reset mid-stream:
  - Stimulus: drop reset at word 5.
  - Required: out_valid=0, out_data=0, overrun=0 asynchronously; after release, stays IDLE until the next digest_valid.
